seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 151 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD conversion (sequential double dabble) plus a time-multiplexed
// driver for a 4-digit common-anode 7-segment display.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_OVERFLOW = 2**19 - 1,
    parameter bit          BLANK_LEADING    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] to_display_nr,
    output logic        busy,
    output logic [3:0]  digit_select,
    output logic [6:0]  led_select
);

    localparam int CNT_W = (REFRESH_OVERFLOW > 0) ? $clog2(REFRESH_OVERFLOW + 1) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state_q, state_d;
    logic [13:0] last_q;
    logic        valid_q;
    logic        overrange_q;
    logic [13:0] shift_q;
    logic [15:0] scratch_q;
    logic [3:0]  iter_q;
    logic [15:0] bcd_q;
    logic [CNT_W-1:0] refresh_q;
    logic [1:0]  index_q;

    logic        capture, start, over_set, finish;
    logic [29:0] dd_next;
    logic [3:0]  cur_digit;
    logic [15:0] upper_digits;
    logic        blank;
    logic [6:0]  led_next;

    function automatic logic [15:0] dabble_adjust(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'h40;
            4'd1:    c = 7'h79;
            4'd2:    c = 7'h24;
            4'd3:    c = 7'h30;
            4'd4:    c = 7'h19;
            4'd5:    c = 7'h12;
            4'd6:    c = 7'h02;
            4'd7:    c = 7'h78;
            4'd8:    c = 7'h00;
            4'd9:    c = 7'h10;
            default: c = 7'h7F;
        endcase
        return c;
    endfunction

    // One double-dabble iteration: adjust then shift the whole {scratch, shift} pair.
    assign dd_next = {dabble_adjust(scratch_q), shift_q} << 1;

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        start    = 1'b0;
        over_set = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!valid_q || (to_display_nr != last_q)) begin
                    capture = 1'b1;
                    if (to_display_nr > 14'd9999) begin
                        over_set = 1'b1;
                    end else begin
                        start   = 1'b1;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                if (iter_q == 4'd13) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == CONV);

    // A digit is blank when it and every higher digit are zero; units always lit.
    always_comb begin
        cur_digit    = bcd_q[{index_q, 2'b00} +: 4];
        upper_digits = bcd_q >> {index_q, 2'b00};
        blank        = BLANK_LEADING && (index_q != 2'd0) && (upper_digits == 16'd0);
        if (overrange_q)  led_next = 7'h3F;
        else if (blank)   led_next = 7'h7F;
        else              led_next = seg_code(cur_digit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= '0;
            valid_q      <= 1'b0;
            overrange_q  <= 1'b0;
            shift_q      <= '0;
            scratch_q    <= '0;
            iter_q       <= '0;
            bcd_q        <= '0;
            refresh_q    <= '0;
            index_q      <= '0;
            digit_select <= 4'b1111;
            led_select   <= 7'h7F;
        end else begin
            state_q <= state_d;
            if (capture) begin
                last_q  <= to_display_nr;
                valid_q <= 1'b1;
            end
            if (over_set) overrange_q <= 1'b1;
            if (start) begin
                shift_q     <= to_display_nr;
                scratch_q   <= '0;
                iter_q      <= '0;
                overrange_q <= 1'b0;
            end
            if (state_q == CONV) begin
                scratch_q <= dd_next[29:14];
                shift_q   <= dd_next[13:0];
                iter_q    <= iter_q + 4'd1;
                if (finish) bcd_q <= dd_next[29:14];
            end
            if (refresh_q == CNT_W'(REFRESH_OVERFLOW)) begin
                refresh_q <= '0;
                index_q   <= index_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + CNT_W'(1);
            end
            digit_select <= ~(4'b0001 << index_q);
            led_select   <= led_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver against an integer-level
// model of the displayed number, scan position and conversion timing.
module tb_seg7_scan_driver;

    localparam int OVF = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] to_display_nr;
    logic        busy, busy_nb;
    logic [3:0]  digit_select, digit_select_nb;
    logic [6:0]  led_select, led_select_nb;

    int n_vec  = 0;
    int n_fail = 0;

    // model state
    int m_valid, m_last, m_over, m_left, m_pending, m_disp, m_cnt, m_idx;
    logic       exp_busy;
    logic [3:0] exp_ds;
    logic [6:0] exp_led, exp_led_nb;

    seg7_scan_driver #(.REFRESH_OVERFLOW(OVF), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .reset(reset), .to_display_nr(to_display_nr),
        .busy(busy), .digit_select(digit_select), .led_select(led_select)
    );

    seg7_scan_driver #(.REFRESH_OVERFLOW(OVF), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .to_display_nr(to_display_nr),
        .busy(busy_nb), .digit_select(digit_select_nb), .led_select(led_select_nb)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] code_of(int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] seg_of(int v, int over, int k, bit blank_on);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (over != 0) return 7'h3F;
        if (blank_on && k > 0 && v < p) return 7'h7F;
        return code_of((v / p) % 10);
    endfunction

    task automatic model_edge();
        logic [3:0] one;
        one = 4'b0001;
        if (reset) begin
            m_valid = 0; m_last = 0; m_over = 0; m_left = 0; m_pending = 0;
            m_disp = 0; m_cnt = 0; m_idx = 0;
            exp_ds = 4'hF; exp_led = 7'h7F; exp_led_nb = 7'h7F;
        end else begin
            exp_ds     = ~(one << m_idx);
            exp_led    = seg_of(m_disp, m_over, m_idx, 1'b1);
            exp_led_nb = seg_of(m_disp, m_over, m_idx, 1'b0);
            if (m_cnt == OVF) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt = m_cnt + 1;
            end
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) m_disp = m_pending;
            end else if (m_valid == 0 || int'(to_display_nr) != m_last) begin
                m_last  = int'(to_display_nr);
                m_valid = 1;
                if (m_last > 9999) begin
                    m_over = 1;
                end else begin
                    m_pending = m_last;
                    m_left    = 14;
                    m_over    = 0;
                end
            end
        end
        exp_busy = (m_left > 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        to_display_nr = 14'd0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_vec++;
            if ({busy, busy_nb, digit_select, led_select, digit_select_nb, led_select_nb}
                !== {1'b0, 1'b0, 4'hF, 7'h7F, 4'hF, 7'h7F}) begin
                n_fail++;
                $display("FAIL reset: got busy=%b ds=%b led=%h ds_nb=%b led_nb=%h, need 0 1111 7f 1111 7f",
                         busy, digit_select, led_select, digit_select_nb, led_select_nb);
            end
        end
    endtask

    task automatic test_power_up_zero();
        int busy_cycles = 0;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (busy === 1'b1) busy_cycles++;
            n_vec++;
            if ({busy, busy_nb, digit_select, led_select, digit_select_nb, led_select_nb}
                !== {exp_busy, exp_busy, exp_ds, exp_led, exp_ds, exp_led_nb}) begin
                n_fail++;
                $display("FAIL power_up cyc %0d: got %b %b %h %b %h, need %b %b %h %b %h", i,
                         busy, digit_select, led_select, digit_select_nb, led_select_nb,
                         exp_busy, exp_ds, exp_led, exp_ds, exp_led_nb);
            end
        end
        n_vec++;
        if (busy_cycles != 14) begin
            n_fail++;
            $display("FAIL busy_length: got %0d cycles, need 14", busy_cycles);
        end
    endtask

    task automatic test_value_1234();
        logic [6:0] want;
        to_display_nr = 14'd1234;
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_vec++;
            if ({busy, digit_select, led_select, led_select_nb}
                !== {exp_busy, exp_ds, exp_led, exp_led_nb}) begin
                n_fail++;
                $display("FAIL v1234 cyc %0d: got %b %b %h %h, need %b %b %h %h", i,
                         busy, digit_select, led_select, led_select_nb,
                         exp_busy, exp_ds, exp_led, exp_led_nb);
            end
        end
        for (int i = 0; i < 16; i++) begin
            cyc();
            case (digit_select)
                4'b1110: want = 7'h19;
                4'b1101: want = 7'h30;
                4'b1011: want = 7'h24;
                4'b0111: want = 7'h79;
                default: want = 7'h7F;
            endcase
            n_vec++;
            if (digit_select === 4'b1111 || led_select !== want) begin
                n_fail++;
                $display("FAIL scan1234: ds=%b got led=%h, need %h", digit_select, led_select, want);
            end
        end
    endtask

    task automatic test_overrange();
        to_display_nr = 14'd9999;
        for (int i = 0; i < 24; i++) begin
            cyc();
            n_vec++;
            if ({busy, digit_select, led_select, led_select_nb}
                !== {exp_busy, exp_ds, exp_led, exp_led_nb}) begin
                n_fail++;
                $display("FAIL v9999 cyc %0d: got %b %b %h %h, need %b %b %h %h", i,
                         busy, digit_select, led_select, led_select_nb,
                         exp_busy, exp_ds, exp_led, exp_led_nb);
            end
        end
        to_display_nr = 14'd10000;
        cyc();
        for (int i = 0; i < 12; i++) begin
            cyc();
            n_vec++;
            if ({busy, led_select, led_select_nb} !== {1'b0, 7'h3F, 7'h3F} || digit_select !== exp_ds) begin
                n_fail++;
                $display("FAIL overrange cyc %0d: got busy=%b ds=%b led=%h led_nb=%h, need 0 %b 3f 3f", i,
                         busy, digit_select, led_select, led_select_nb, exp_ds);
            end
        end
    endtask

    task automatic test_change_during_conv();
        to_display_nr = 14'd57;
        for (int i = 0; i < 4; i++) cyc();
        to_display_nr = 14'd800;
        for (int i = 0; i < 50; i++) begin
            cyc();
            n_vec++;
            if ({busy, digit_select, led_select, led_select_nb}
                !== {exp_busy, exp_ds, exp_led, exp_led_nb}) begin
                n_fail++;
                $display("FAIL change_in_conv cyc %0d: got %b %b %h %h, need %b %b %h %h", i,
                         busy, digit_select, led_select, led_select_nb,
                         exp_busy, exp_ds, exp_led, exp_led_nb);
            end
        end
    endtask

    task automatic test_no_blank();
        logic [6:0] want_nb, want_b;
        to_display_nr = 14'd7;
        for (int i = 0; i < 20; i++) cyc();
        for (int i = 0; i < 16; i++) begin
            cyc();
            want_nb = (digit_select === 4'b1110) ? 7'h78 : 7'h40;
            want_b  = (digit_select === 4'b1110) ? 7'h78 : 7'h7F;
            n_vec++;
            if (led_select_nb !== want_nb || led_select !== want_b || digit_select_nb !== exp_ds) begin
                n_fail++;
                $display("FAIL no_blank: ds=%b got led_nb=%h led=%h, need %h %h",
                         digit_select, led_select_nb, led_select, want_nb, want_b);
            end
        end
    endtask

    task automatic test_reset_mid_conv();
        to_display_nr = 14'd4321;
        for (int i = 0; i < 5; i++) cyc();
        reset = 1'b1;
        cyc();
        n_vec++;
        if ({busy, digit_select, led_select} !== {1'b0, 4'hF, 7'h7F}) begin
            n_fail++;
            $display("FAIL reset_mid_conv: got %b %b %h, need 0 1111 7f", busy, digit_select, led_select);
        end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            n_vec++;
            if ({busy, digit_select, led_select, led_select_nb}
                !== {exp_busy, exp_ds, exp_led, exp_led_nb}) begin
                n_fail++;
                $display("FAIL after_reset cyc %0d: got %b %b %h %h, need %b %b %h %h", i,
                         busy, digit_select, led_select, led_select_nb,
                         exp_busy, exp_ds, exp_led, exp_led_nb);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 3) == 0) to_display_nr = 14'($urandom_range(10000, 16383));
            else if ($urandom_range(0, 2) == 0) to_display_nr = 14'($urandom_range(0, 99));
            else to_display_nr = 14'($urandom_range(0, 9999));
            hold = $urandom_range(1, 24);
            for (int i = 0; i < hold; i++) begin
                cyc();
                n_vec++;
                if ({busy, busy_nb, digit_select, led_select, digit_select_nb, led_select_nb}
                    !== {exp_busy, exp_busy, exp_ds, exp_led, exp_ds, exp_led_nb}) begin
                    n_fail++;
                    $display("FAIL random val %0d: got %b %b %h %b %h, need %b %b %h %b %h",
                             to_display_nr, busy, digit_select, led_select, digit_select_nb,
                             led_select_nb, exp_busy, exp_ds, exp_led, exp_ds, exp_led_nb);
                end
            end
        end
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_vec++;
            if ({busy, digit_select, led_select, led_select_nb}
                !== {exp_busy, exp_ds, exp_led, exp_led_nb}) begin
                n_fail++;
                $display("FAIL random_settle: got %b %b %h %h, need %b %b %h %h",
                         busy, digit_select, led_select, led_select_nb,
                         exp_busy, exp_ds, exp_led, exp_led_nb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up_zero();
        test_value_1234();
        test_overrange();
        test_change_during_conv();
        test_no_blank();
        test_reset_mid_conv();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
